// File: rtl/apu_cluster_package.sv
// Shared constants for the APU cluster FP units.
package apu_cluster_package;
    localparam int FP_WIDTH      = 32;
    localparam int NUSFLAGS_CAST = 5;
endpackage

// File: rtl/fp_result_fifo.sv
// Generic DEPTH x WIDTH registered FIFO, no fall-through.
module fp_result_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] last_q;
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // When drained, the head keeps showing the most recently popped entry.
    assign data_o = empty_o ? last_q : mem_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            last_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                last_q   <= mem_q[rd_ptr_q];
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/fp_cast_result_buffer.sv
// Credit-managed result buffer behind the FP cast unit.
module fp_cast_result_buffer
    import apu_cluster_package::*;
#(
    parameter int DEPTH      = 4,
    parameter int TAG_WIDTH  = 4,
    parameter int STAT_WIDTH = NUSFLAGS_CAST
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  IssueEn_i,
    output logic                  IssueReady_o,
    input  logic                  Valid_i,
    input  logic [FP_WIDTH-1:0]   Res_i,
    input  logic [TAG_WIDTH-1:0]  Tag_i,
    input  logic [STAT_WIDTH-1:0] Status_i,
    output logic                  ResValid_o,
    input  logic                  ResReady_i,
    output logic [FP_WIDTH-1:0]   Res_o,
    output logic [TAG_WIDTH-1:0]  Tag_o,
    output logic [STAT_WIDTH-1:0] Status_o,
    output logic [STAT_WIDTH-1:0] StatusSticky_o,
    input  logic                  StatusClr_i,
    output logic                  Overflow_o,
    output logic                  Empty_o
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = FP_WIDTH + TAG_WIDTH + STAT_WIDTH;

    logic [CW-1:0]         inflight_q, inflight_d;
    logic [CW-1:0]         count;
    logic [STAT_WIDTH-1:0] sticky_q, sticky_d;
    logic                  overflow_q;
    logic                  full, empty, push, pop, err;
    logic [EW-1:0]         head;

    fp_result_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .data_i  ({Res_i, Tag_i, Status_i}),
        .pop_i   (pop),
        .data_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count)
    );

    assign ResValid_o = !empty;
    assign pop        = ResValid_o && ResReady_i;
    assign push       = Valid_i && (!full || pop);

    // Credits cover both queued and in-flight results.
    assign IssueReady_o = ((CW+1)'(count) + (CW+1)'(inflight_q))
                          < (CW+1)'(DEPTH);

    assign err = (IssueEn_i && !IssueReady_o)
              || (Valid_i && (inflight_q == '0))
              || (Valid_i && full && !pop);

    assign {Res_o, Tag_o, Status_o} = head;
    assign StatusSticky_o = sticky_q;
    assign Overflow_o     = overflow_q;
    assign Empty_o        = empty && (inflight_q == '0);

    always_comb begin
        inflight_d = inflight_q;
        unique case (1'b1)
            IssueEn_i && !Valid_i:
                if (inflight_q != CW'(DEPTH)) inflight_d = inflight_q + CW'(1);
            Valid_i && !IssueEn_i:
                if (inflight_q != '0) inflight_d = inflight_q - CW'(1);
            default: inflight_d = inflight_q;
        endcase
    end

    always_comb begin
        sticky_d = (StatusClr_i ? '0 : sticky_q) | (push ? Status_i : '0);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            inflight_q <= '0;
            sticky_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
            sticky_q   <= sticky_d;
            overflow_q <= overflow_q | err;
        end
    end

endmodule

// File: tb/tb_fp_cast_result_buffer.sv
// Randomized bench for fp_cast_result_buffer against a queue model.
module tb_fp_cast_result_buffer;

    typedef logic [40:0] ent_t;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        IssueEn_i = 1'b0;
    logic        IssueReady_o;
    logic        Valid_i = 1'b0;
    logic [31:0] Res_i = '0;
    logic [3:0]  Tag_i = '0;
    logic [4:0]  Status_i = '0;
    logic        ResValid_o;
    logic        ResReady_i = 1'b0;
    logic [31:0] Res_o;
    logic [3:0]  Tag_o;
    logic [4:0]  Status_o;
    logic [4:0]  StatusSticky_o;
    logic        StatusClr_i = 1'b0;
    logic        Overflow_o;
    logic        Empty_o;

    fp_cast_result_buffer dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .IssueEn_i      (IssueEn_i),
        .IssueReady_o   (IssueReady_o),
        .Valid_i        (Valid_i),
        .Res_i          (Res_i),
        .Tag_i          (Tag_i),
        .Status_i       (Status_i),
        .ResValid_o     (ResValid_o),
        .ResReady_i     (ResReady_i),
        .Res_o          (Res_o),
        .Tag_o          (Tag_o),
        .Status_o       (Status_o),
        .StatusSticky_o (StatusSticky_o),
        .StatusClr_i    (StatusClr_i),
        .Overflow_o     (Overflow_o),
        .Empty_o        (Empty_o)
    );

    always #5 clk_i = ~clk_i;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: queue of buffered results plus scalar state.
    ent_t       mq[$];
    int         infl;
    bit         m_ovf;
    logic [4:0] m_sticky;
    ent_t       m_last;

    // Cast unit emulation: fixed 2-cycle delay from issue to result.
    bit   pv[2];
    ent_t pe[2];
    bit   use_fix = 0;
    ent_t fix_ent;

    logic [49:0] dut_vec;
    assign dut_vec = {ResValid_o, IssueReady_o, Empty_o, Overflow_o,
                      StatusSticky_o, Res_o, Tag_o, Status_o};

    function automatic ent_t rand_ent();
        logic [31:0] r = $urandom;
        logic [3:0]  t = 4'($urandom_range(15));
        logic [4:0]  s = 5'($urandom_range(31));
        return {r, t, s};
    endfunction

    function automatic bit m_ready();
        return (mq.size() + infl) < 4;
    endfunction

    function automatic logic [49:0] exp_vec();
        ent_t h = (mq.size() > 0) ? mq[0] : m_last;
        bit rv = mq.size() > 0;
        bit em = (mq.size() == 0) && (infl == 0);
        return {rv, m_ready(), em, m_ovf, m_sticky, h};
    endfunction

    task automatic model_reset();
        mq.delete();
        infl = 0;
        m_ovf = 0;
        m_sticky = '0;
        m_last = '0;
        pv[0] = 0;
        pv[1] = 0;
    endtask

    task automatic model_step(input bit iss, input bit v, input bit rdy,
                              input bit clr, input ent_t e);
        int cnt = mq.size();
        bit pop = (cnt > 0) && rdy;
        bit push = v && (cnt < 4 || pop);
        if ((iss && !m_ready()) || (v && infl == 0) || (v && cnt == 4 && !pop))
            m_ovf = 1;
        if (pop) m_last = mq.pop_front();
        if (push) mq.push_back(e);
        if (iss && !v) begin
            if (infl < 4) infl++;
        end else if (v && !iss) begin
            if (infl > 0) infl--;
        end
        m_sticky = (clr ? 5'b0 : m_sticky) | (push ? e[4:0] : 5'b0);
    endtask

    task automatic cycle(input bit iss, input bit rdy, input bit clr,
                         input bit inj);
        ent_t e;
        e = pv[1] ? pe[1] : rand_ent();
        IssueEn_i = iss;
        ResReady_i = rdy;
        StatusClr_i = clr;
        Valid_i = pv[1] | inj;
        {Res_i, Tag_i, Status_i} = e;
        @(posedge clk_i);
        model_step(iss, Valid_i, rdy, clr, e);
        pv[1] = pv[0];
        pe[1] = pe[0];
        pv[0] = iss;
        pe[0] = use_fix ? fix_ent : rand_ent();
        @(negedge clk_i);
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        IssueEn_i = 0;
        Valid_i = 0;
        ResReady_i = 0;
        StatusClr_i = 0;
        model_reset();
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if (dut_vec !== exp_vec()) begin
            miscompares++;
            $display("FAIL reset_state got %h exp %h", dut_vec, exp_vec());
        end
        vectors++;
        if ({IssueReady_o, Empty_o, ResValid_o, Res_o} !== {1'b1, 1'b1, 1'b0, 32'h0}) begin
            miscompares++;
            $display("FAIL reset_flags got rdy=%b emp=%b val=%b res=%h exp 1 1 0 0",
                     IssueReady_o, Empty_o, ResValid_o, Res_o);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] vals [4] = '{32'h3F800000, 32'h40000000,
                                  32'h40400000, 32'h40800000};
        int seen = 0;
        use_fix = 1;
        for (int i = 0; i < 10; i++) begin
            if (i < 4) fix_ent = {vals[i], 4'(i + 1), 5'b0};
            cycle(i < 4, 1, 0, 0);
            vectors++;
            if (dut_vec !== exp_vec()) begin
                miscompares++;
                $display("FAIL b2b cyc%0d got %h exp %h", i, dut_vec, exp_vec());
            end
            if (ResValid_o === 1'b1) begin
                vectors++;
                if ({Res_o, Tag_o} !== {vals[seen], 4'(seen + 1)}) begin
                    miscompares++;
                    $display("FAIL b2b_order got %h/%0d exp %h/%0d",
                             Res_o, Tag_o, vals[seen], seen + 1);
                end
                if (seen < 3) seen++;
            end
        end
        use_fix = 0;
        vectors++;
        if (Empty_o !== 1'b1 || seen != 3) begin
            miscompares++;
            $display("FAIL b2b_end got empty=%b seen=%0d exp 1 3", Empty_o, seen);
        end
    endtask

    task automatic test_stall();
        ent_t first;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            cycle(i < 4, 0, 0, 0);
            if (i == 3) begin
                vectors++;
                if (IssueReady_o !== 1'b0) begin
                    miscompares++;
                    $display("FAIL stall_credit got %b exp 0", IssueReady_o);
                end
            end
            vectors++;
            if (dut_vec !== exp_vec()) begin
                miscompares++;
                $display("FAIL stall cyc%0d got %h exp %h", i, dut_vec, exp_vec());
            end
        end
        first = mq[0];
        vectors++;
        if ({ResValid_o, Res_o, Tag_o, Status_o} !== {1'b1, first}) begin
            miscompares++;
            $display("FAIL stall_head got %h exp %h", {Res_o, Tag_o, Status_o}, first);
        end
        cycle(0, 1, 0, 0);
        vectors++;
        if (IssueReady_o !== 1'b1) begin
            miscompares++;
            $display("FAIL stall_release got %b exp 1", IssueReady_o);
        end
        for (int i = 0; i < 4; i++) begin
            cycle(0, 1, 0, 0);
            vectors++;
            if (dut_vec !== exp_vec()) begin
                miscompares++;
                $display("FAIL stall_drain cyc%0d got %h exp %h", i, dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_sticky();
        logic [4:0] st [3] = '{5'b00001, 5'b10000, 5'b00100};
        do_reset();
        use_fix = 1;
        for (int i = 0; i < 6; i++) begin
            if (i < 3) fix_ent = {32'h1234_0000 + 32'(i), 4'(i), st[i]};
            if (i == 4) begin
                vectors++;
                if (StatusSticky_o !== 5'b10001) begin
                    miscompares++;
                    $display("FAIL sticky_pre got %b exp 10001", StatusSticky_o);
                end
            end
            cycle(i < 3, 1, i == 4, 0);
            if (i == 4) begin
                vectors++;
                if (StatusSticky_o !== 5'b00100) begin
                    miscompares++;
                    $display("FAIL sticky_clr got %b exp 00100", StatusSticky_o);
                end
            end
            vectors++;
            if (dut_vec !== exp_vec()) begin
                miscompares++;
                $display("FAIL sticky cyc%0d got %h exp %h", i, dut_vec, exp_vec());
            end
        end
        use_fix = 0;
    endtask

    task automatic test_stream();
        do_reset();
        for (int i = 0; i < 90; i++) begin
            bit iss = m_ready() && ($urandom_range(3) != 0) && (i < 84);
            bit rdy = ($urandom_range(2) != 0) || (i >= 84);
            cycle(iss, rdy, $urandom_range(7) == 0, 0);
            vectors++;
            if (dut_vec !== exp_vec()) begin
                miscompares++;
                $display("FAIL stream cyc%0d got %h exp %h", i, dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_full_push_pop();
        do_reset();
        for (int i = 0; i < 7; i++) cycle(i < 4, 0, 0, 0);
        cycle(0, 1, 0, 1);
        vectors++;
        if ({ResValid_o, IssueReady_o, Overflow_o} !== 3'b101) begin
            miscompares++;
            $display("FAIL full_pp_flags got %b exp 101",
                     {ResValid_o, IssueReady_o, Overflow_o});
        end
        for (int i = 0; i < 6; i++) begin
            vectors++;
            if (dut_vec !== exp_vec()) begin
                miscompares++;
                $display("FAIL full_pp cyc%0d got %h exp %h", i, dut_vec, exp_vec());
            end
            cycle(0, 1, 0, 0);
        end
    endtask

    task automatic test_protocol();
        do_reset();
        for (int i = 0; i < 7; i++) cycle(i < 4, 0, 0, 0);
        vectors++;
        if (Overflow_o !== 1'b0) begin
            miscompares++;
            $display("FAIL proto_clean got %b exp 0", Overflow_o);
        end
        cycle(1, 0, 0, 0);
        vectors++;
        if (Overflow_o !== 1'b1) begin
            miscompares++;
            $display("FAIL proto_issue got %b exp 1", Overflow_o);
        end
        for (int i = 0; i < 8; i++) begin
            cycle(0, i > 3, 0, 0);
            vectors++;
            if (dut_vec !== exp_vec()) begin
                miscompares++;
                $display("FAIL proto cyc%0d got %h exp %h", i, dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 4; i++) cycle(i < 3, 0, 0, 0);
        vectors++;
        if (mq.size() != 2 || infl != 1 || dut_vec !== exp_vec()) begin
            miscompares++;
            $display("FAIL rst_mid_pre got %h exp %h cnt=%0d infl=%0d",
                     dut_vec, exp_vec(), mq.size(), infl);
        end
        #2;
        rst_ni = 1'b0;
        Valid_i = 1'b1;
        #1;
        vectors++;
        if ({ResValid_o, IssueReady_o, Empty_o, StatusSticky_o, Overflow_o}
            !== {3'b011, 5'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL rst_async got %b exp 011000000",
                     {ResValid_o, IssueReady_o, Empty_o, StatusSticky_o, Overflow_o});
        end
        model_reset();
        @(posedge clk_i);
        @(negedge clk_i);
        vectors++;
        if (dut_vec !== exp_vec()) begin
            miscompares++;
            $display("FAIL rst_hold got %h exp %h", dut_vec, exp_vec());
        end
        Valid_i = 1'b0;
        rst_ni = 1'b1;
        cycle(0, 1, 0, 0);
        vectors++;
        if (dut_vec !== exp_vec()) begin
            miscompares++;
            $display("FAIL rst_after got %h exp %h", dut_vec, exp_vec());
        end
    endtask

    initial begin
        model_reset();
        @(negedge clk_i);
        test_reset();
        test_back_to_back();
        test_stall();
        test_sticky();
        test_stream();
        test_full_push_pop();
        test_protocol();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
